// File: rtl/uart_frame_tx_if.sv
// Byte-fetch and serial-line bundle for the frame transmitter.
// master drives start/rd_data; slave is the transmitter itself.
interface uart_frame_tx_if #(
    parameter int IDX_W = 6
) ();
    logic             start;
    logic [7:0]       rd_data;
    logic [IDX_W-1:0] rd_idx;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        output start, rd_data,
        input  rd_idx, tx, busy, done
    );

    modport slave (
        input  start, rd_data,
        output rd_idx, tx, busy, done
    );
endinterface

// File: rtl/uart_frame_tx.sv
// UART 8N1 frame transmitter: sends bank bytes 0..FRAME_LEN-1 LSB-first.
// Define UART_FRAME_TX_SYNC_EN to prefix each frame with a 0xA5 sync byte.
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FRAME_LEN    = 55,
    parameter int IDX_W        = 6
) (
    input  logic          clk,
    input  logic          reset,
    uart_frame_tx_if.slave bus
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]    BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_FRAME_TX_SYNC_EN
        S_STOP,
        S_SYNC
`else
        S_STOP
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_FRAME_TX_SYNC_EN
    logic             sync_q, sync_d;
`endif
    logic             baud_last;

    assign baud_last  = (baud_q == BAUD_MAX);
    assign bus.rd_idx = idx_q;
    assign bus.tx     = tx_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    // State and datapath registers; reset drops the line high at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_FRAME_TX_SYNC_EN
            sync_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_FRAME_TX_SYNC_EN
            sync_q  <= sync_d;
`endif
        end
    end

    // Next-state logic; tx is derived from the next state so it is registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;
`ifdef UART_FRAME_TX_SYNC_EN
        sync_d  = sync_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                // the done cycle itself never accepts a new request
                if (bus.start && !done_q) begin
                    idx_d  = '0;
                    busy_d = 1'b1;
                    baud_d = '0;
                    bit_d  = '0;
`ifdef UART_FRAME_TX_SYNC_EN
                    state_d = S_SYNC;
`else
                    state_d = S_LOAD;
`endif
                end
            end
`ifdef UART_FRAME_TX_SYNC_EN
            S_SYNC: begin
                shift_d = 8'hA5;
                sync_d  = 1'b1;
                baud_d  = '0;
                state_d = S_START;
            end
`endif
            S_LOAD: begin
                shift_d = bus.rd_data;
                baud_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
`ifdef UART_FRAME_TX_SYNC_EN
                    if (sync_q) begin
                        sync_d  = 1'b0;
                        state_d = S_LOAD;
                    end else
`endif
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end
endmodule
